// File: rtl/riscv_core_pkg.sv
// Shared definitions for the branch resolve unit: funct3 branch encodings,
// the BHT counter type with its reset value, and the saturating counter step.
package riscv_core_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef logic [1:0] bht_cnt_t;

    // Weakly not-taken.
    localparam bht_cnt_t BHT_RESET_VAL = 2'b01;

    // Two-bit saturating counter step: taken counts up, not-taken counts down.
    function automatic bht_cnt_t bht_next(input bht_cnt_t cur, input logic taken);
        bht_cnt_t nxt;
        nxt = cur;
        if (taken && (cur != 2'b11)) begin
            nxt = cur + 2'(1);
        end else if (!taken && (cur != 2'b00)) begin
            nxt = cur - 2'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/riscv_core_bht.sv
// Branch history table: array of 2-bit saturating counters.
// Ports:
//   clk, rst   clock and synchronous active-high reset (all entries -> 01)
//   rd_idx     lookup index; rd_cnt_c is the combinational counter read
//   wr_en      apply one saturating step to entry wr_idx at the clock edge
//   wr_taken   direction of that step
// A read of the entry being written in the same cycle returns the old value.
module riscv_core_bht
    import riscv_core_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_cnt_t         rd_cnt_c,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_cnt_t mem [ENTRIES];

    assign rd_cnt_c = mem[rd_idx];

    // Counter storage with saturating update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                mem[i] <= BHT_RESET_VAL;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= bht_next(mem[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/riscv_core_branch_resolve_unit.sv
// Branch resolve stage: evaluates branch/jump conditions, compares against the
// fetch prediction, registers the result one cycle later, trains the BHT and
// keeps saturating branch/mispredict event counters.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_valid, i_flush                  request strobe and same-cycle kill
//   i_srcA, i_srcB, i_funct3          branch operands and condition
//   i_is_jump, i_is_compressed        jal/jalr flag, 16-bit instruction flag
//   i_pc, i_target, i_pred_taken      resolving PC, taken target, prediction
//   i_lookup_pc, o_lookup_taken       fetch-side BHT lookup (combinational)
//   o_valid .. o_illegal              registered resolve result
//   o_branch_cnt, o_mispredict_cnt    event counters
module riscv_core_branch_resolve_unit
    import riscv_core_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned C_EXT       = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_flush,
    input  logic [XLEN-1:0]  i_srcA,
    input  logic [XLEN-1:0]  i_srcB,
    input  logic [2:0]       i_funct3,
    input  logic             i_is_jump,
    input  logic             i_is_compressed,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_target,
    input  logic             i_pred_taken,
    input  logic [XLEN-1:0]  i_lookup_pc,
    output logic             o_lookup_taken,
    output logic             o_valid,
    output logic             o_istaken,
    output logic             o_mispredict,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_addr_misaligned,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispredict_cnt
);

    localparam int unsigned IDX_W   = $clog2(BHT_ENTRIES);
    // Halfword-granular index when compressed instructions exist.
    localparam int unsigned IDX_LSB = (C_EXT != 0) ? 1 : 2;

    logic             taken_c;
    logic             illegal_c;
    logic             mis_c;
    logic             mispredict_c;
    logic             accept_c;
    logic             bht_wr_c;
    logic [XLEN-1:0]  fall_c;
    bht_cnt_t         lookup_cnt_c;
    logic             unused_lookup;

    // Only the index slice of the lookup PC matters.
    assign unused_lookup = ^i_lookup_pc;

    // Branch condition evaluation.
    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        if (i_is_jump) begin
            taken_c = 1'b1;
        end else begin
            case (i_funct3)
                BEQ:     taken_c = (i_srcA == i_srcB);
                BNE:     taken_c = (i_srcA != i_srcB);
                BLT:     taken_c = ($signed(i_srcA) <  $signed(i_srcB));
                BGE:     taken_c = ($signed(i_srcA) >= $signed(i_srcB));
                BLTU:    taken_c = (i_srcA <  i_srcB);
                BGEU:    taken_c = (i_srcA >= i_srcB);
                default: illegal_c = 1'b1;
            endcase
        end
    end

    assign mis_c        = taken_c & ((C_EXT != 0) ? i_target[0] : |i_target[1:0]);
    assign mispredict_c = (taken_c != i_pred_taken) & ~mis_c & ~illegal_c;
    assign fall_c       = i_pc + (i_is_compressed ? XLEN'(2) : XLEN'(4));
    assign accept_c     = i_valid & ~i_flush;
    assign bht_wr_c     = accept_c & ~i_is_jump & ~illegal_c & ~mis_c;

    assign o_lookup_taken = lookup_cnt_c[1];

    riscv_core_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk      (i_clk),
        .rst      (i_rst),
        .rd_idx   (i_lookup_pc[IDX_LSB +: IDX_W]),
        .rd_cnt_c (lookup_cnt_c),
        .wr_en    (bht_wr_c),
        .wr_idx   (i_pc[IDX_LSB +: IDX_W]),
        .wr_taken (taken_c)
    );

    // Result registers and event counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid           <= 1'b0;
            o_istaken         <= 1'b0;
            o_mispredict      <= 1'b0;
            o_addr_misaligned <= 1'b0;
            o_illegal         <= 1'b0;
            o_redirect_pc     <= '0;
            o_branch_cnt      <= '0;
            o_mispredict_cnt  <= '0;
        end else begin
            o_valid           <= accept_c;
            o_istaken         <= accept_c & taken_c;
            o_mispredict      <= accept_c & mispredict_c;
            o_addr_misaligned <= accept_c & mis_c;
            o_illegal         <= accept_c & illegal_c;
            // Redirect address holds between mispredicts.
            if (accept_c && mispredict_c) begin
                o_redirect_pc <= taken_c ? i_target : fall_c;
            end
            if (accept_c && (o_branch_cnt != '1)) begin
                o_branch_cnt <= o_branch_cnt + CNT_W'(1);
            end
            if (accept_c && mispredict_c && (o_mispredict_cnt != '1)) begin
                o_mispredict_cnt <= o_mispredict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_riscv_core_branch_resolve_unit.sv
// Scoreboard bench for riscv_core_branch_resolve_unit. Expected results are
// pushed when a request is driven and popped the cycle the DUT shows them.
// A second instance with C_EXT=0 shares the inputs for the alignment rule.
module tb_riscv_core_branch_resolve_unit;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            i_rst = 1'b1;
    logic            i_valid = 1'b0;
    logic            i_flush = 1'b0;
    logic [63:0]     i_srcA = '0;
    logic [63:0]     i_srcB = '0;
    logic [2:0]      i_funct3 = '0;
    logic            i_is_jump = 1'b0;
    logic            i_is_compressed = 1'b0;
    logic [63:0]     i_pc = '0;
    logic [63:0]     i_target = '0;
    logic            i_pred_taken = 1'b0;
    logic [63:0]     i_lookup_pc = '0;

    logic            o_lookup_taken, o_valid, o_istaken, o_mispredict;
    logic [63:0]     o_redirect_pc;
    logic            o_addr_misaligned, o_illegal;
    logic [31:0]     o_branch_cnt, o_mispredict_cnt;

    logic            n_lookup_taken, n_valid, n_istaken, n_mispredict;
    logic [63:0]     n_redirect_pc;
    logic            n_addr_misaligned, n_illegal;
    logic [31:0]     n_branch_cnt, n_mispredict_cnt;
    logic            unused_n;

    assign unused_n = ^{n_lookup_taken, n_istaken, n_mispredict, n_redirect_pc,
                        n_branch_cnt, n_mispredict_cnt};

    riscv_core_branch_resolve_unit #(
        .XLEN(XLEN), .BHT_ENTRIES(64), .C_EXT(1), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
        .i_srcA(i_srcA), .i_srcB(i_srcB), .i_funct3(i_funct3),
        .i_is_jump(i_is_jump), .i_is_compressed(i_is_compressed),
        .i_pc(i_pc), .i_target(i_target), .i_pred_taken(i_pred_taken),
        .i_lookup_pc(i_lookup_pc), .o_lookup_taken(o_lookup_taken),
        .o_valid(o_valid), .o_istaken(o_istaken), .o_mispredict(o_mispredict),
        .o_redirect_pc(o_redirect_pc), .o_addr_misaligned(o_addr_misaligned),
        .o_illegal(o_illegal), .o_branch_cnt(o_branch_cnt),
        .o_mispredict_cnt(o_mispredict_cnt)
    );

    riscv_core_branch_resolve_unit #(
        .XLEN(XLEN), .BHT_ENTRIES(64), .C_EXT(0), .CNT_W(CNT_W)
    ) dut_nc (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
        .i_srcA(i_srcA), .i_srcB(i_srcB), .i_funct3(i_funct3),
        .i_is_jump(i_is_jump), .i_is_compressed(i_is_compressed),
        .i_pc(i_pc), .i_target(i_target), .i_pred_taken(i_pred_taken),
        .i_lookup_pc(i_lookup_pc), .o_lookup_taken(n_lookup_taken),
        .o_valid(n_valid), .o_istaken(n_istaken), .o_mispredict(n_mispredict),
        .o_redirect_pc(n_redirect_pc), .o_addr_misaligned(n_addr_misaligned),
        .o_illegal(n_illegal), .o_branch_cnt(n_branch_cnt),
        .o_mispredict_cnt(n_mispredict_cnt)
    );

    typedef struct {
        logic istaken;
        logic mispredict;
        logic mis;
        logic illegal;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  m_bht [64];
    logic [31:0] m_br;
    logic [31:0] m_mp;
    logic [63:0] m_redir;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        m_br    = '0;
        m_mp    = '0;
        m_redir = '0;
        sb_q.delete();
    endtask

    // Compare the registered outputs against the scoreboard and model state.
    task automatic check_out();
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("valid",      64'(o_valid),           64'd1);
            chk("istaken",    64'(o_istaken),         64'(e.istaken));
            chk("mispredict", 64'(o_mispredict),      64'(e.mispredict));
            chk("misaligned", 64'(o_addr_misaligned), 64'(e.mis));
            chk("illegal",    64'(o_illegal),         64'(e.illegal));
        end else begin
            chk("idle_valid",      64'(o_valid),           64'd0);
            chk("idle_istaken",    64'(o_istaken),         64'd0);
            chk("idle_mispredict", 64'(o_mispredict),      64'd0);
            chk("idle_misaligned", 64'(o_addr_misaligned), 64'd0);
            chk("idle_illegal",    64'(o_illegal),         64'd0);
        end
        chk("redirect_pc",    o_redirect_pc,          m_redir);
        chk("branch_cnt",     64'(o_branch_cnt),      64'(m_br));
        chk("mispredict_cnt", 64'(o_mispredict_cnt),  64'(m_mp));
    endtask

    // Drive one cycle, check the same-cycle lookup, update the model, then
    // check registered outputs after the edge.
    task automatic issue(input logic v, input logic fl, input logic [2:0] f3,
                         input logic jmp, input logic cmp,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] pc, input logic [63:0] tgt,
                         input logic pred, input logic [63:0] lk);
        logic        t, ill, mis, mp;
        logic [63:0] fall;
        logic [1:0]  cnt;
        @(negedge clk);
        i_valid = v; i_flush = fl; i_funct3 = f3; i_is_jump = jmp;
        i_is_compressed = cmp; i_srcA = a; i_srcB = b; i_pc = pc;
        i_target = tgt; i_pred_taken = pred; i_lookup_pc = lk;
        #1;
        cnt = m_bht[lk[6:1]];
        chk("lookup", 64'(o_lookup_taken), 64'(cnt[1]));
        if (v && !fl) begin
            t = 1'b0; ill = 1'b0;
            case (f3)
                3'b000: t = (a == b);
                3'b001: t = (a != b);
                3'b100: t = ($signed(a) < $signed(b));
                3'b101: t = ($signed(a) >= $signed(b));
                3'b110: t = (a < b);
                3'b111: t = (a >= b);
                default: ill = 1'b1;
            endcase
            if (jmp) begin
                t = 1'b1; ill = 1'b0;
            end
            mis  = t & tgt[0];
            mp   = (t != pred) & ~mis & ~ill;
            fall = pc + (cmp ? 64'd2 : 64'd4);
            sb_q.push_back('{t, mp, mis, ill});
            if (mp) m_redir = t ? tgt : fall;
            if (!jmp && !ill && !mis) begin
                cnt = m_bht[pc[6:1]];
                if (t && cnt != 2'b11) cnt = cnt + 2'd1;
                else if (!t && cnt != 2'b00) cnt = cnt - 2'd1;
                m_bht[pc[6:1]] = cnt;
            end
            if (m_br != '1) m_br = m_br + 32'd1;
            if (mp && m_mp != '1) m_mp = m_mp + 32'd1;
        end
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle(input logic [63:0] lk);
        issue(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, lk);
    endtask

    task automatic do_reset(input logic with_req);
        @(negedge clk);
        i_rst   = 1'b1;
        i_valid = with_req;
        i_flush = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_out();
        @(negedge clk);
        i_rst   = 1'b0;
        i_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] ra, rb, rpc, rtg;
        logic [2:0]  rf;

        model_reset();
        do_reset(1'b0);
        idle(64'h0);
        idle(64'h1234);

        // BEQ equal operands predicted not-taken -> redirect to target.
        issue(1, 0, 3'b000, 0, 0, 64'd5, 64'd5, 64'h1000, 64'h1040, 0, 64'h1000);
        chk("beq_redirect", o_redirect_pc, 64'h1040);
        chk("beq_mpcnt", 64'(o_mispredict_cnt), 64'd1);

        // Signed vs unsigned compare on -1 / 1, compressed, predicted taken.
        issue(1, 0, 3'b100, 0, 1, '1, 64'd1, 64'h2000, 64'h2100, 1, 64'h0);
        issue(1, 0, 3'b110, 0, 1, '1, 64'd1, 64'h2000, 64'h2100, 1, 64'h0);
        chk("bltu_redirect", o_redirect_pc, 64'h2002);
        idle(64'h0);

        // BHT saturation at 0x3000 with same-cycle lookup of the same index.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++)
            issue(1, 0, 3'b000, 0, 0, 64'd7, 64'd7, 64'h3000, 64'h3100, 1, 64'h3000);
        idle(64'h3000);
        issue(1, 0, 3'b001, 0, 0, 64'd7, 64'd7, 64'h3000, 64'h3100, 0, 64'h3000);
        idle(64'h3000);
        chk("bht_weak_taken", 64'(o_lookup_taken), 64'd1);
        issue(1, 0, 3'b001, 0, 0, 64'd7, 64'd7, 64'h3000, 64'h3100, 0, 64'h3000);
        idle(64'h3000);
        chk("bht_weak_not", 64'(o_lookup_taken), 64'd0);

        // Taken misaligned conditional branch leaves the BHT alone.
        issue(1, 0, 3'b000, 0, 0, 64'd1, 64'd1, 64'h3000, 64'h3001, 0, 64'h3000);
        idle(64'h3000);

        // JAL misalignment, both alignment rules.
        issue(1, 0, 3'b000, 1, 0, 64'd0, 64'd3, 64'h4000, 64'h4001, 0, 64'h4000);
        chk("nc_mis_4001", 64'(n_addr_misaligned), 64'd1);
        issue(1, 0, 3'b000, 1, 0, 64'd0, 64'd3, 64'h4000, 64'h4002, 1, 64'h4000);
        chk("nc_mis_4002", 64'(n_addr_misaligned), 64'd1);
        chk("nc_valid", 64'(n_valid), 64'd1);

        // Unsupported funct3, then valid with flush.
        issue(1, 0, 3'b010, 0, 0, 64'd1, 64'd1, 64'h3000, 64'h3100, 1, 64'h3000);
        chk("nc_illegal", 64'(n_illegal), 64'd1);
        issue(1, 0, 3'b011, 0, 0, 64'd1, 64'd2, 64'h3000, 64'h3100, 0, 64'h3000);
        issue(1, 1, 3'b000, 0, 0, 64'd1, 64'd1, 64'h3000, 64'h3100, 0, 64'h3000);
        idle(64'h3000);

        // Fall-through wraps at the top of the address space.
        issue(1, 0, 3'b000, 0, 0, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 1, 64'h0);
        chk("wrap_redirect", o_redirect_pc, 64'h0);

        // Back-to-back random traffic.
        for (int i = 0; i < 48; i++) begin
            rf  = 3'($urandom_range(0, 7));
            ra  = {32'($urandom), 32'($urandom)};
            rb  = ($urandom_range(0, 2) == 0) ? ra : {32'($urandom), 32'($urandom)};
            rpc = {56'h0, 8'($urandom)} & ~64'h1;
            rtg = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) != 0) rtg[0] = 1'b0;
            issue(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) == 0), rf,
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                  ra, rb, rpc, rtg, 1'($urandom_range(0, 1)),
                  {56'h0, 8'($urandom)});
        end

        // Reset the cycle after a request, and reset overriding a request.
        issue(1, 0, 3'b000, 0, 0, 64'd9, 64'd9, 64'h5000, 64'h5100, 0, 64'h0);
        do_reset(1'b1);
        idle(64'h5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_core_branch_resolve_unit.md
Name: riscv_core_branch_resolve_unit

Overview:
- Registered branch resolution stage for the RV64IMAC core. It evaluates conditional branches and jumps from execute, compares the outcome with the fetch-side prediction, and raises a redirect on mispredict.
- Owns a parametrised 2-bit-counter branch history table (BHT). Fetch reads the BHT combinationally; resolve writes it.
- Flags misaligned taken targets; the misalignment rule is C-extension aware.
- Provides saturating branch and mispredict event counters for the performance CSRs.

Parameters:
- XLEN, 64, datapath and PC width.
- BHT_ENTRIES, 64, BHT depth; must be a power of two, 2 to 1024.
- C_EXT, 1, 1 = 16-bit instruction alignment allowed; 0 = 32-bit alignment required.
- CNT_W, 32, width of each event counter.

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  resolve request valid this cycle.
- i_flush  in  1  kill the in-flight result; suppresses updates this cycle.
- i_srcA  in  XLEN  rs1 operand.
- i_srcB  in  XLEN  rs2 operand.
- i_funct3  in  3  branch condition.
- i_is_jump  in  1  jal/jalr; taken unconditionally, funct3 ignored.
- i_is_compressed  in  1  resolving instruction is 16-bit.
- i_pc  in  XLEN  PC of the resolving instruction.
- i_target  in  XLEN  computed taken target.
- i_pred_taken  in  1  prediction supplied by fetch.
- i_lookup_pc  in  XLEN  fetch lookup PC.
- o_lookup_taken  out  1  combinational prediction: BHT counter MSB.
- o_valid  out  1  registered result valid.
- o_istaken  out  1  registered resolved direction.
- o_mispredict  out  1  registered redirect request.
- o_redirect_pc  out  XLEN  registered redirect address.
- o_addr_misaligned  out  1  registered instruction-address-misaligned exception.
- o_illegal  out  1  registered: unsupported funct3 (010 or 011) on a non-jump.
- o_branch_cnt  out  CNT_W  resolved-branch event counter.
- o_mispredict_cnt  out  CNT_W  mispredict event counter.

Behaviour:
- Reset (synchronous, i_rst=1 at a rising edge):
  - All registered outputs are 0, including o_redirect_pc and both counters.
  - Every BHT entry is set to 2'b01 (weakly not-taken).
  - Reset overrides i_valid and i_flush in the same cycle. Reset mid-stream discards the pending result.
- Index width: IDX_W = log2(BHT_ENTRIES).
  - Index is pc[1 +: IDX_W] when C_EXT=1, otherwise pc[2 +: IDX_W].
  - The same slice is used for lookup and update.
- Condition evaluation (combinational, inside the cycle):
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010 and 011 give taken=0 and illegal=1.
  - i_is_jump forces taken=1 and illegal=0.
- Misalignment:
  - mis = taken & (C_EXT ? i_target[0] : |i_target[1:0]).
  - Only taken paths are checked.
- Fall-through address: i_pc + (i_is_compressed ? 2 : 4), modulo 2^XLEN, so wrap at the top of the address space is legal.
- Latency: exactly one cycle. An accepted request at edge N gives o_valid=1 during cycle N+1. Back-to-back requests every cycle are supported; there is no backpressure.
- Result registers at edge N, when i_valid & ~i_flush:
  - o_valid=1, o_istaken=taken, o_illegal=illegal, o_addr_misaligned=mis.
  - o_mispredict = (taken != i_pred_taken) & ~mis & ~illegal.
  - o_redirect_pc = taken ? i_target : fall-through. It is updated only when o_mispredict is set; otherwise it holds its value.
  - All other cases (no request, or flushed): o_valid, o_istaken, o_mispredict, o_addr_misaligned and o_illegal are 0.
- BHT update: only on a conditional branch (~i_is_jump) that is valid, not flushed, not illegal and not misaligned.
  - Taken increments the counter, saturating at 11.
  - Not-taken decrements the counter, saturating at 00.
- Lookup/update to the same index in the same cycle: lookup returns the pre-update value (read-before-write).
- Event counters:
  - o_branch_cnt increments on every accepted conditional branch or jump.
  - o_mispredict_cnt increments on every cycle where a mispredict is registered.
  - Both saturate at all-ones.
- i_flush asserted with i_valid: no result, no BHT update, no counter update.

Decomposition:
- Package riscv_core_pkg holds:
  - the funct3 branch constants (BEQ, BNE, BLT, BGE, BLTU, BGEU);
  - typedef bht_cnt_t (logic [1:0]);
  - constant BHT_RESET_VAL = 2'b01.
- One sub-module, riscv_core_bht: the BHT storage array with saturating-update logic, one combinational read port and one synchronous write port.
- Condition compare and the result registers stay in the top level.

Test Plan:
- Reset, then lookup any PC -> o_lookup_taken=0. Outputs and counters are 0 and o_redirect_pc=0.
- BEQ with srcA=srcB=5, pred=0, pc=0x1000, target=0x1040 -> next cycle o_istaken=1, o_mispredict=1, o_redirect_pc=0x1040, o_mispredict_cnt=1.
- BLT with srcA=-1, srcB=1 and BLTU with the same operands, both pred=1, compressed, pc=0x2000:
  - BLT -> taken, no mispredict.
  - BLTU -> not taken, o_mispredict=1, o_redirect_pc=0x2002.
- Four taken resolves at pc=0x3000 starting from 01 -> counter saturates at 11 (lookup=1). Then one not-taken resolve -> 10 (lookup still 1). Same-cycle lookup of the updated index returns the old value.
- JAL with target=0x4001, C_EXT=1 -> o_addr_misaligned=1, o_mispredict=0, BHT unchanged. With C_EXT=0, target=0x4002 -> misaligned=1.
- Edge cases:
  - funct3=010 -> o_illegal=1, no BHT update.
  - i_valid together with i_flush -> o_valid=0 and counters unchanged.
  - i_rst asserted the cycle after a request -> all outputs 0.
  - pc=0xFFFF_FFFF_FFFF_FFFC with not-taken mispredict -> o_redirect_pc=0.
